// File: rtl/vblank_access_arbiter.sv
// rtl/vblank_access_arbiter.sv - round-robin write arbiter for the object-state table, open only during vertical blanking
`timescale 1ns/1ps
module vblank_access_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int V_DISPLAY   = 480,
    parameter int V_TOTAL     = 525,
    parameter int GUARD_LINES = 2,
    parameter int MAX_HOLD    = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         v_counter,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    input  logic               clr_flags,
    output logic [NUM_REQ-1:0] grant,
    output logic               frame_tick,
    output logic               active,
    output logic               overrun,
    output logic               timeout
);
    localparam int                PTR_W     = $clog2(NUM_REQ);
    localparam int                HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [9:0]        WIN_LO    = 10'(V_DISPLAY);
    localparam logic [9:0]        WIN_HI    = 10'(V_TOTAL - GUARD_LINES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_win_q;
    logic                r_frame_tick;
    logic                r_active;
    logic                r_overrun;
    logic                r_timeout;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_served;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [PTR_W-1:0]    r_rr_ptr;

    logic                w_win_c;
    logic [NUM_REQ-1:0]  w_cand;
    logic                w_found;
    logic [PTR_W-1:0]    w_winner;
    logic [NUM_REQ-1:0]  w_grant_next;
    logic [NUM_REQ-1:0]  w_served_next;
    logic [HOLD_W-1:0]   w_hold_next;
    logic [PTR_W-1:0]    w_rr_next;
    logic                w_set_overrun;
    logic                w_set_timeout;

    assign w_win_c = (v_counter >= WIN_LO) && (v_counter < WIN_HI);
    assign w_cand  = req & ~r_served;

    // First pending requester at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin : winner_search
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_found && w_cand[idx[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_served_next = r_served;
        w_hold_next   = r_hold_cnt;
        w_rr_next     = r_rr_ptr;
        w_set_overrun = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_next = '0;
                if (r_win_q) w_state_next = S_ARB;
            end
            S_ARB: begin
                w_grant_next = '0;
                if (!r_win_q) begin
                    w_state_next = S_IDLE;
                end else if (w_found) begin
                    w_grant_next  = NUM_REQ'(1) << w_winner;
                    w_served_next = r_served | (NUM_REQ'(1) << w_winner);
                    w_hold_next   = '0;
                    w_rr_next     = (w_winner == PTR_LAST) ? '0 : w_winner + PTR_W'(1);
                    w_state_next  = S_GRANT;
                end
            end
            S_GRANT: begin
                // Window close outranks a simultaneous done: the write may be torn.
                if (!r_win_q) begin
                    w_grant_next  = '0;
                    w_set_overrun = 1'b1;
                    w_state_next  = S_IDLE;
                end else if (|(done & r_grant) || !(|(req & r_grant))) begin
                    w_grant_next = '0;
                    w_state_next = S_ARB;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_grant_next  = '0;
                    w_set_timeout = 1'b1;
                    w_state_next  = S_ARB;
                end else begin
                    w_hold_next = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_grant_next = '0;
                w_state_next = S_IDLE;
            end
        endcase
        if (w_win_c && !r_win_q) w_served_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_win_q      <= 1'b0;
            r_frame_tick <= 1'b0;
            r_active     <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
            r_grant      <= '0;
            r_served     <= '0;
            r_hold_cnt   <= '0;
            r_rr_ptr     <= '0;
        end else begin
            r_state      <= w_state_next;
            r_win_q      <= w_win_c;
            r_frame_tick <= w_win_c & ~r_win_q;
            r_active     <= (w_state_next != S_IDLE);
            r_grant      <= w_grant_next;
            r_served     <= w_served_next;
            r_hold_cnt   <= w_hold_next;
            r_rr_ptr     <= w_rr_next;
            if (w_set_overrun)  r_overrun <= 1'b1;
            else if (clr_flags) r_overrun <= 1'b0;
            if (w_set_timeout)  r_timeout <= 1'b1;
            else if (clr_flags) r_timeout <= 1'b0;
        end
    end

    assign grant      = r_grant;
    assign frame_tick = r_frame_tick;
    assign active     = r_active;
    assign overrun    = r_overrun;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_vblank_access_arbiter.sv
// tb/tb_vblank_access_arbiter.sv - directed self-checking bench for vblank_access_arbiter
`timescale 1ns/1ps
module tb_vblank_access_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] v_counter;
    logic [3:0] req;
    logic [3:0] done;
    logic       clr_flags;
    logic [3:0] grant;
    logic       frame_tick;
    logic       active;
    logic       overrun;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    vblank_access_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .v_counter  (v_counter),
        .req        (req),
        .done       (done),
        .clr_flags  (clr_flags),
        .grant      (grant),
        .frame_tick (frame_tick),
        .active     (active),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int cycles);
        cycles = 0;
        while (grant == 4'b0000 && cycles < 600) begin
            tick();
            cycles++;
        end
    endtask

    task automatic close_window();
        v_counter = 10'd0;
        repeat (3) tick();
    endtask

    // Waits for a grant, holds it so done lands 10 clocks after grant rises, then checks width and drop.
    task automatic serve(input string tag, input logic [3:0] exp, input int exp_wait, input logic [3:0] req_after);
        int w;
        int width;
        wait_grant(w);
        check_eq({tag, "_grant"}, 32'(grant), 32'(exp));
        check_eq({tag, "_wait"}, 32'(w), 32'(exp_wait));
        width = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (grant == exp) width++;
        end
        done = exp;
        req  = req_after;
        tick();
        done = 4'b0000;
        check_eq({tag, "_width"}, 32'(width), 32'd11);
        check_eq({tag, "_drop"}, 32'(grant), 32'd0);
    endtask

    initial begin
        int tick_cnt;
        int tick_ok;
        int act_bad;
        int w;
        int width;
        logic [3:0] gsum;

        rst_n = 1'b0; v_counter = 10'd0; req = 4'b0000; done = 4'b0000; clr_flags = 1'b0;
        repeat (3) tick();
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_tick", 32'(frame_tick), 32'd0);
        check_eq("rst_active", 32'(active), 32'd0);
        check_eq("rst_flags", 32'({overrun, timeout}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Sweep one frame at 4 clocks per line, sampling the first clock of each line.
        tick_cnt = 0; tick_ok = 0; act_bad = 0; gsum = 4'b0000;
        for (int l = 0; l < 525; l++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) begin
                    v_counter = 10'(l);
                    if (active !== ((l >= 481 && l <= 523) ? 1'b1 : 1'b0)) act_bad++;
                end
                if (frame_tick) begin
                    tick_cnt++;
                    if (l == 480 && c == 1) tick_ok++;
                end
                gsum = gsum | grant;
                tick();
            end
        end
        check_eq("sweep_tick_count", 32'(tick_cnt), 32'd1);
        check_eq("sweep_tick_place", 32'(tick_ok), 32'd1);
        check_eq("sweep_active_lines", 32'(act_bad), 32'd0);
        check_eq("sweep_no_grant", 32'(gsum), 32'd0);

        // Full round: four requesters in order, gap of one idle clock.
        close_window();
        req = 4'b1111;
        v_counter = 10'd480;
        serve("a0", 4'b0001, 3, 4'b1111);
        serve("a1", 4'b0010, 1, 4'b1111);
        serve("a2", 4'b0100, 1, 4'b1111);
        serve("a3", 4'b1000, 1, 4'b1111);
        gsum = 4'b0000;
        repeat (20) begin tick(); gsum = gsum | grant; end
        check_eq("a_no_regrant", 32'(gsum), 32'd0);
        check_eq("a_active", 32'(active), 32'd1);

        // New frame starts from rr_ptr=0; dropping req with done leaves rr_ptr=1.
        close_window();
        v_counter = 10'd480;
        serve("b0", 4'b0001, 3, 4'b0000);

        close_window();
        req = 4'b0101;
        v_counter = 10'd480;
        serve("c0", 4'b0100, 3, 4'b0101);
        serve("c1", 4'b0001, 1, 4'b0000);

        // MAX_HOLD expiry.
        close_window();
        req = 4'b0010;
        v_counter = 10'd480;
        wait_grant(w);
        check_eq("d_grant", 32'(grant), 32'b0010);
        width = 0;
        while (grant == 4'b0010 && width < 300) begin
            width++;
            tick();
        end
        check_eq("d_width", 32'(width), 32'd256);
        check_eq("d_timeout", 32'(timeout), 32'd1);
        gsum = 4'b0000;
        repeat (20) begin tick(); gsum = gsum | grant; end
        check_eq("d_no_regrant", 32'(gsum), 32'd0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check_eq("d_clr", 32'(timeout), 32'd0);

        // Grant cut by window close.
        close_window();
        req = 4'b0001;
        v_counter = 10'd522;
        wait_grant(w);
        check_eq("e_grant", 32'(grant), 32'b0001);
        repeat (2) tick();
        v_counter = 10'd523;
        tick();
        check_eq("e_hold", 32'(grant), 32'b0001);
        tick();
        check_eq("e_drop", 32'(grant), 32'd0);
        check_eq("e_overrun", 32'(overrun), 32'd1);
        check_eq("e_idle", 32'(active), 32'd0);

        // Asynchronous reset mid-grant.
        close_window();
        req = 4'b0100;
        v_counter = 10'd480;
        wait_grant(w);
        check_eq("f_grant", 32'(grant), 32'b0100);
        tick();
        #5;
        rst_n = 1'b0;
        #1;
        check_eq("f_async_grant", 32'(grant), 32'd0);
        check_eq("f_async_flags", 32'({active, overrun, timeout}), 32'd0);
        v_counter = 10'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        gsum = 4'b0000;
        repeat (10) begin tick(); gsum = gsum | grant; end
        check_eq("f_no_grant", 32'(gsum), 32'd0);
        v_counter = 10'd480;
        wait_grant(w);
        check_eq("f_regrant", 32'(grant), 32'b0100);
        check_eq("f_regrant_wait", 32'(w), 32'd3);

        // Reset released inside the window.
        rst_n = 1'b0;
        v_counter = 10'd500;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("g_tick", 32'(frame_tick), 32'd1);
        wait_grant(w);
        check_eq("g_grant", 32'(grant), 32'b0100);
        check_eq("g_wait", 32'(w), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
